// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, flag indices, FSM states and branch evaluation for alu_seq
package alu_seq_pkg;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_CMP = 4'd2, OP_ADC = 4'd3,
                         OP_SBC = 4'd4, OP_AND = 4'd5, OP_OR = 4'd6, OP_XOR = 4'd7,
                         OP_MOV = 4'd8, OP_MUL = 4'd9;
  localparam logic [3:0] OP_NEG = 4'd0, OP_COM = 4'd1, OP_LSL = 4'd2, OP_LSR = 4'd3,
                         OP_ROL = 4'd4, OP_ROR = 4'd5, OP_RLC = 4'd6, OP_RRC = 4'd7,
                         OP_LSLN = 4'd8, OP_LSRN = 4'd9, OP_ASRN = 4'd10;
  localparam logic [3:0] OP_BREQ = 4'd0, OP_BRNE = 4'd1, OP_BRLT = 4'd2, OP_BRGE = 4'd3,
                         OP_BRC = 4'd4, OP_BRLO = 4'd4, OP_BRNC = 4'd5, OP_BRSH = 4'd5,
                         OP_BRO = 4'd6, OP_BRNO = 4'd7, OP_BRN = 4'd8, OP_BRNN = 4'd9,
                         OP_RJMP = 4'd10;
  localparam int FLAG_C = 3, FLAG_V = 2, FLAG_Z = 1, FLAG_N = 0;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_FIN} state_t;
  function automatic logic branch_taken(input logic [3:0] bop, input logic [3:0] f);
    case (bop)
      OP_BREQ: return f[FLAG_Z];
      OP_BRNE: return !f[FLAG_Z];
      OP_BRLT: return f[FLAG_N] ^ f[FLAG_V];
      OP_BRGE: return !(f[FLAG_N] ^ f[FLAG_V]);
      OP_BRC:  return f[FLAG_C];
      OP_BRNC: return !f[FLAG_C];
      OP_BRO:  return f[FLAG_V];
      OP_BRNO: return !f[FLAG_V];
      OP_BRN:  return f[FLAG_N];
      OP_BRNN: return !f[FLAG_N];
      OP_RJMP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/alu_seq_mul.sv
// alu_mul_seq: shift-add unsigned multiplier, one multiplier bit per cycle
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] mcand;
  logic [CW-1:0] cnt;
  logic run;
  logic [WIDTH:0] sum;
  assign sum = {1'b0, hi} + {1'b0, (lo[0] ? mcand : {WIDTH{1'b0}})};
  assign done = run && cnt == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      run <= 1'b0;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      mcand <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= CW'(WIDTH);
      hi <= '0;
      lo <= b;
      mcand <= a;
    end else if (run) begin
      if (cnt == '0) run <= 1'b0;
      else begin
        hi <= sum[WIDTH:1];
        lo <= {sum[0], lo[WIDTH-1:1]};
        cnt <= cnt - CW'(1);
      end
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with registered C/V/Z/N flags, start/done handshake and branch check
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             single,
  input  logic [3:0]       operator,
  input  logic [WIDTH-1:0] value1,
  input  logic [WIDTH-1:0] value2,
  input  logic [3:0]       branch_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             check_branch
);
  localparam int SHW = $clog2(WIDTH);
  localparam int M = WIDTH - 1;
  state_t state, nxt;
  logic [3:0] op;
  logic sgl, sc, cf, launch, is_mul, is_shn, ready, mul_done, c, v, keep_res;
  logic [WIDTH-1:0] a, b, sh, mul_hi, mul_lo, r, rh;
  logic [SHW-1:0] cnt;
  logic [WIDTH:0] ar;
  logic [3:0] nf;
  assign cf = flags[FLAG_C];
  assign launch = state == ST_IDLE && start;
  assign is_mul = !sgl && op == OP_MUL;
  assign is_shn = sgl && (op == OP_LSLN || op == OP_LSRN || op == OP_ASRN);
  assign ready = is_mul ? mul_done : is_shn ? cnt == '0 : 1'b1;
  assign busy = state != ST_IDLE;
  assign done = state == ST_FIN;
  assign check_branch = branch_taken(branch_op, flags);
  assign nf = {c, v, ~|{rh, r}, r[M]};
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .rst(rst), .start(launch && !single && operator == OP_MUL),
    .a(value1), .b(value2), .done(mul_done), .hi(mul_hi), .lo(mul_lo)
  );
  always_comb nxt = state == ST_IDLE ? (start ? ST_EXEC : ST_IDLE) :
                    state == ST_EXEC ? (ready ? ST_FIN : ST_EXEC) : ST_IDLE;
  always_comb begin
    ar = '0;
    r = a;
    rh = '0;
    c = cf;
    v = 1'b0;
    keep_res = 1'b0;
    if (!sgl) begin
      case (op)
        OP_ADD, OP_ADC: begin
          ar = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, op == OP_ADC && cf};
          r = ar[M:0];
          c = ar[WIDTH];
          v = a[M] == b[M] && r[M] != a[M];
        end
        OP_SUB, OP_SBC, OP_CMP: begin
          ar = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, op == OP_SBC && cf};
          r = ar[M:0];
          c = ar[WIDTH];
          v = a[M] != b[M] && r[M] != a[M];
          keep_res = op == OP_CMP;
        end
        OP_AND: r = a & b;
        OP_OR:  r = a | b;
        OP_XOR: r = a ^ b;
        OP_MOV: r = b;
        OP_MUL: begin
          r = mul_lo;
          rh = mul_hi;
          c = |mul_hi;
        end
        default: r = {(WIDTH/2){2'b10}};
      endcase
    end else begin
      case (op)
        OP_NEG: begin
          ar = {(WIDTH+1){1'b0}} - {1'b0, a};
          r = ar[M:0];
          c = ar[WIDTH];
          v = a[M] && r[M];
        end
        OP_COM: r = ~a;
        OP_LSL: begin r = {a[M-1:0], 1'b0}; c = a[M]; v = r[M] ^ a[M]; end
        OP_LSR: begin r = {1'b0, a[M:1]}; c = a[0]; v = r[M] ^ a[M]; end
        OP_ROL: begin r = {a[M-1:0], a[M]}; c = a[M]; v = r[M] ^ a[M]; end
        OP_ROR: begin r = {a[0], a[M:1]}; c = a[0]; v = r[M] ^ a[M]; end
        OP_RLC: begin r = {a[M-1:0], cf}; c = a[M]; v = r[M] ^ a[M]; end
        OP_RRC: begin r = {cf, a[M:1]}; c = a[0]; v = r[M] ^ a[M]; end
        OP_LSLN, OP_LSRN, OP_ASRN: begin r = sh; c = sc; v = r[M] ^ a[M]; end
        default: r = '0;
      endcase
    end
  end
  // sc starts as the stored carry so a zero shift count leaves C untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      result <= '0;
      result_hi <= '0;
      flags <= '0;
      op <= '0;
      sgl <= 1'b0;
      a <= '0;
      b <= '0;
      sh <= '0;
      cnt <= '0;
      sc <= 1'b0;
    end else begin
      state <= nxt;
      if (launch) begin
        op <= operator;
        sgl <= single;
        a <= value1;
        b <= value2;
        sh <= value1;
        cnt <= value2[SHW-1:0];
        sc <= flags[FLAG_C];
      end else if (state == ST_EXEC) begin
        if (is_shn && cnt != '0) begin
          cnt <= cnt - SHW'(1);
          sc <= op == OP_LSLN ? sh[M] : sh[0];
          sh <= op == OP_LSLN ? {sh[M-1:0], 1'b0} : {op == OP_ASRN && sh[M], sh[M:1]};
        end
        if (ready) begin
          flags <= nf;
          if (!keep_res) begin
            result <= r;
            result_hi <= rh;
          end
        end
      end
    end
  end
endmodule
